// File: rtl/mult_share_ctrl_pkg.sv
// Shared types and default sizing for the multiplier-sharing controller.
// Optional watchdog is selected elsewhere with MULT_TIMEOUT_EN.
package mult_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CLEAR   = 3'd3,
    RESPOND = 3'd4
  } state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_OP_W    = 8;
  localparam int DEF_PROD_W  = 16;
  localparam int DEF_TIMEOUT = 32;

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Bundle of requester, multiplier and response signals around mult_share_ctrl.
// master = controller side, slave = requesters/multiplier/consumer side.
interface mult_share_ctrl_if #(
  parameter int N_REQ  = 4,
  parameter int OP_W   = 8,
  parameter int PROD_W = 16
);
  localparam int ID_W = $clog2(N_REQ);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; req_valid and rsp_valid hold with stable payload until then.
  // mul_valid is a one-cycle start pulse; mul_ready is a level cleared only by
  // mul_clr or reset.
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*OP_W-1:0] req_a;
  logic [N_REQ*OP_W-1:0] req_b;
  logic [N_REQ-1:0]      req_ready;

  logic                  mul_valid;
  logic [OP_W-1:0]       mul_a;
  logic [OP_W-1:0]       mul_b;
  logic                  mul_clr;
  logic                  mul_ready;
  logic [PROD_W-1:0]     mul_product;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [PROD_W-1:0]     rsp_product;
  logic                  rsp_err;

  modport master (
    input  req_valid, req_a, req_b, mul_ready, mul_product, rsp_ready,
    output req_ready, mul_valid, mul_a, mul_b, mul_clr,
           rsp_valid, rsp_id, rsp_product, rsp_err
  );

  modport slave (
    output req_valid, req_a, req_b, mul_ready, mul_product, rsp_ready,
    input  req_ready, mul_valid, mul_a, mul_b, mul_clr,
           rsp_valid, rsp_id, rsp_product, rsp_err
  );

endinterface

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping; returns one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int              pos;
  logic [ID_W-1:0] pos_i;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    pos_i = '0;
    for (int off = 0; off < N_REQ; off++) begin
      pos = int'(ptr) + off;
      if (pos >= N_REQ) pos = pos - N_REQ;
      pos_i = ID_W'(pos);
      if (!any && req[pos_i]) begin
        any          = 1'b1;
        idx          = pos_i;
        grant[pos_i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one multiplier between N_REQ requesters: grant, issue, wait, clear, respond.
// Define MULT_TIMEOUT_EN to add a WAIT-state watchdog that reports rsp_err.
module mult_share_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int  N_REQ   = DEF_N_REQ,
  parameter int  OP_W    = DEF_OP_W,
  parameter int  PROD_W  = DEF_PROD_W,
  parameter int  TIMEOUT = DEF_TIMEOUT,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              reset,
  mult_share_ctrl_if.master bus,
  output state_t            dbg_state,
  output logic [ID_W-1:0]   dbg_ptr
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, id_q, grant_idx;
  logic [N_REQ-1:0]  grant_oh;
  logic              grant_any, grant_go, tmo_hit;
  logic [OP_W-1:0]   a_q, b_q, sel_a, sel_b;
  logic [PROD_W-1:0] prod_q;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant_oh),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Gated by reset so no accept pulse leaks out while reset is held.
  assign grant_go = (state_q == IDLE) && grant_any && !reset;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_a = bus.req_a[i*OP_W +: OP_W];
        sel_b = bus.req_b[i*OP_W +: OP_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_go) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.mul_ready || tmo_hit) state_d = CLEAR;
      CLEAR:   state_d = RESPOND;
      RESPOND: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= '0;
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
    end else begin
      if (grant_go) begin
        ptr_q <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        id_q  <= grant_idx;
        a_q   <= sel_a;
        b_q   <= sel_b;
      end
      // mul_ready is only trusted in WAIT; a stale level during ISSUE is ignored.
      if (state_q == WAIT) begin
        if (bus.mul_ready) prod_q <= bus.mul_product;
        else if (tmo_hit)  prod_q <= '0;
      end
    end
  end

`ifdef MULT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 wait_cnt_q <= '0;
    else if (state_q == WAIT)  wait_cnt_q <= wait_cnt_q + 1'b1;
    else                       wait_cnt_q <= '0;
  end

  assign tmo_hit = (state_q == WAIT) && !bus.mul_ready &&
                   (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         err_q <= 1'b0;
    else if (grant_go) err_q <= 1'b0;
    else if (tmo_hit)  err_q <= 1'b1;
  end

  assign bus.rsp_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
  assign bus.rsp_err    = 1'b0;
`endif

  assign bus.req_ready   = grant_go ? grant_oh : '0;
  assign bus.mul_valid   = (state_q == ISSUE);
  assign bus.mul_clr     = (state_q == CLEAR);
  assign bus.mul_a       = a_q;
  assign bus.mul_b       = b_q;
  assign bus.rsp_valid   = (state_q == RESPOND);
  assign bus.rsp_id      = id_q;
  assign bus.rsp_product = prod_q;
  assign dbg_state       = state_q;
  assign dbg_ptr         = ptr_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with a behavioural multiplier and a
// response scoreboard; MULT_TIMEOUT_EN selects the watchdog expectations.
module tb_mult_share_ctrl;
  import mult_ctrl_pkg::*;

  localparam int N_REQ  = 4;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int ID_W   = 2;
  localparam int SB_W   = 1 + ID_W + PROD_W;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  state_t          dbg_state;
  logic [ID_W-1:0] dbg_ptr;

  mult_share_ctrl_if #(.N_REQ(N_REQ), .OP_W(OP_W), .PROD_W(PROD_W)) bus ();

  mult_share_ctrl #(
    .N_REQ(N_REQ), .OP_W(OP_W), .PROD_W(PROD_W), .TIMEOUT(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus tables (hand-computed products) ----------------
  logic [OP_W-1:0]   op_a [N_REQ] = '{8'd3,  8'd7, 8'h80, 8'h7F};
  logic [OP_W-1:0]   op_b [N_REQ] = '{8'hFB, 8'd9, 8'h80, 8'h80};
  logic [PROD_W-1:0] exp_prod [N_REQ] = '{16'hFFF1, 16'h003F, 16'h4000, 16'hC080};
  int                exp_order [5] = '{0, 1, 2, 3, 0};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural multiplier ----------------
  int              busy = 3;
  bit              hang_mode = 1'b0;
  int              mcnt;
  logic [PROD_W-1:0] pend;

  function automatic logic [PROD_W-1:0] smul(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    int x, y;
    x = $signed(a);
    y = $signed(b);
    return PROD_W'(x * y);
  endfunction

  // ready rises 'busy' cycles after the start cycle and stays until mul_clr/reset
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mul_ready   <= 1'b0;
      bus.mul_product <= '0;
      mcnt            <= 0;
    end else if (bus.mul_clr) begin
      bus.mul_ready   <= 1'b0;
      bus.mul_product <= '0;
      mcnt            <= 0;
    end else if (bus.mul_valid) begin
      pend            <= smul(bus.mul_a, bus.mul_b);
      bus.mul_product <= 16'hA5A5;
      mcnt            <= 0;
      if (!hang_mode) begin
        if (busy == 1) begin
          bus.mul_ready   <= 1'b1;
          bus.mul_product <= smul(bus.mul_a, bus.mul_b);
        end else begin
          mcnt <= busy - 1;
        end
      end
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        bus.mul_ready   <= 1'b1;
        bus.mul_product <= pend;
      end
    end
  end

  // ---------------- monitor + scoreboard ----------------
  int              cyc = 0;
  int              rr_cnt = 0, mv_cnt = 0, mc_cnt = 0, pop_cnt = 0;
  int              rsp_cyc = 0, grant_cyc = 0, clr_at_rsp = 0;
  bit              rsp_seen = 1'b0;
  int              grant_log[$];
  logic [SB_W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      rsp_seen = 1'b0;
    end else begin
      if (bus.req_ready != '0) begin
        check("grant_onehot", $countones(bus.req_ready), 1);
        for (int i = 0; i < N_REQ; i++) begin
          if (bus.req_ready[i]) begin
            grant_log.push_back(i);
            exp_q.push_back({hang_mode, ID_W'(i), hang_mode ? 16'h0000 : exp_prod[i]});
          end
        end
        rr_cnt++;
        grant_cyc = cyc;
      end
      if (bus.mul_valid) mv_cnt++;
      if (bus.mul_clr)   mc_cnt++;
      if (bus.rsp_valid && !rsp_seen) begin
        rsp_seen   = 1'b1;
        rsp_cyc    = cyc;
        clr_at_rsp = mc_cnt;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_seen = 1'b0;
        pop_cnt++;
        if (exp_q.size() == 0) check("sb_unexpected_rsp", 1, 0);
        else check("sb_rsp", {bus.rsp_err, bus.rsp_id, bus.rsp_product}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [N_REQ-1:0] v);
    bus.req_valid = v;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_a[i*OP_W +: OP_W] = op_a[i];
      bus.req_b[i*OP_W +: OP_W] = op_b[i];
    end
  endtask

  task automatic wait_rsp(input string tag);
    int k = 0;
    @(negedge clk);
    while (!bus.rsp_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    #1;
    if (!bus.rsp_valid) check(tag, 0, 1);
  endtask

  task automatic wait_pops(input int target, input string tag);
    int k = 0;
    while (pop_cnt < target && k < 400) begin
      @(negedge clk);
      k++;
    end
    #1;
    if (pop_cnt < target) check(tag, pop_cnt, target);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctrl"}, {bus.req_ready, bus.mul_valid, bus.mul_clr, bus.rsp_valid}, 0);
    check({tag, "_rsp_id"}, bus.rsp_id, 0);
    check({tag, "_rsp_product"}, bus.rsp_product, 0);
    check({tag, "_ops"}, {bus.mul_a, bus.mul_b, bus.rsp_err}, 0);
    check({tag, "_ptr"}, dbg_ptr, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- directed sequence ----------------
  int mv0, mc0, rr0, p0, bad, k;
  logic [ID_W-1:0]   s_id;
  logic [PROD_W-1:0] s_prod;
  logic              s_err;

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    tick();
    reset = 1'b0;

    // T1: single request, signed product, pulse counts and latency
    busy = 3;
    tick();
    set_req(4'b0001);
    mv0 = mv_cnt; mc0 = mc_cnt; p0 = pop_cnt;
    @(negedge clk);
    check("t1_req_ready", bus.req_ready, 4'b0001);
    tick();
    set_req(4'b0000);
    wait_rsp("t1_rsp_wait");
    check("t1_rsp_id", bus.rsp_id, 0);
    check("t1_rsp_product", bus.rsp_product, 16'hFFF1);
    check("t1_mul_a_held", {bus.mul_a, bus.mul_b}, {8'd3, 8'hFB});
    check("t1_mul_valid_pulses", mv_cnt - mv0, 1);
    check("t1_clr_before_rsp", clr_at_rsp - mc0, 1);
    check("t1_latency", rsp_cyc - grant_cyc, 3 + 3);
    wait_pops(p0 + 1, "t1_pop_wait");

    // T2: all four held from reset, served 0,1,2,3,0
    busy = 2;
    set_req(4'b1111);
    reset = 1'b1;
    grant_log.delete();
    tick();
    tick();
    rr0 = rr_cnt; mv0 = mv_cnt; p0 = pop_cnt;
    reset = 1'b0;
    k = 0;
    while (grant_log.size() < 5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    #1;
    tick();
    set_req(4'b0000);
    wait_pops(p0 + 5, "t2_pop_wait");
    check("t2_grants", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check($sformatf("t2_order%0d", i), grant_log[i], exp_order[i]);
    check("t2_req_ready_pulses", rr_cnt - rr0, 5);
    check("t2_mul_valid_pulses", mv_cnt - mv0, 5);

    // T3: response stalled 10 cycles with other requests pending
    check("t3_ptr_start", dbg_ptr, 1);
    bus.rsp_ready = 1'b0;
    p0 = pop_cnt;
    tick();
    set_req(4'b0010);
    @(negedge clk);
    check("t3_req_ready", bus.req_ready, 4'b0010);
    tick();
    set_req(4'b0000);
    wait_rsp("t3_rsp_wait");
    s_id = bus.rsp_id; s_prod = bus.rsp_product; s_err = bus.rsp_err;
    check("t3_rsp_product", s_prod, 16'h003F);
    rr0 = rr_cnt; mv0 = mv_cnt;
    set_req(4'b1101);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_id !== s_id || bus.rsp_product !== s_prod ||
          bus.rsp_err !== s_err || bus.req_ready !== '0 || bus.mul_valid) bad++;
    end
    check("t3_stable", bad, 0);
    check("t3_no_grant", rr_cnt - rr0, 0);
    check("t3_no_mul_valid", mv_cnt - mv0, 0);
    check("t3_state", dbg_state, RESPOND);
    tick();
    set_req(4'b0000);
    bus.rsp_ready = 1'b1;
    wait_pops(p0 + 1, "t3_pop_wait");
    check("t3_ptr_end", dbg_ptr, 2);

    // T6: pointer at 2, only req1 -> wrap-around grant
    p0 = pop_cnt;
    tick();
    set_req(4'b0010);
    @(negedge clk);
    check("t6_wrap_grant", bus.req_ready, 4'b0010);
    tick();
    set_req(4'b0000);
    wait_pops(p0 + 1, "t6_pop_wait");
    check("t6_ptr", dbg_ptr, 2);

    // T4: reset during WAIT, then a fresh request
    busy = 20;
    tick();
    set_req(4'b1000);
    @(negedge clk);
    tick();
    set_req(4'b0000);
    k = 0;
    while (dbg_state != WAIT && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t4_reached_wait", dbg_state, WAIT);
    repeat (3) @(negedge clk);
    tick();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_quiet("t4_in_reset");
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_quiet("t4_after_reset");
    busy = 2;
    p0 = pop_cnt;
    tick();
    set_req(4'b0100);
    @(negedge clk);
    check("t4_req_ready", bus.req_ready, 4'b0100);
    tick();
    set_req(4'b0000);
    wait_rsp("t4_rsp_wait");
    check("t4_rsp_product", bus.rsp_product, 16'h4000);
    check("t4_rsp_id", bus.rsp_id, 2);
    wait_pops(p0 + 1, "t4_pop_wait");

    // T5: multiplier never finishes
    hang_mode = 1'b1;
    mc0 = mc_cnt; p0 = pop_cnt;
    tick();
    set_req(4'b0001);
    @(negedge clk);
    check("t5_req_ready", bus.req_ready, 4'b0001);
    tick();
    set_req(4'b0000);
`ifdef MULT_TIMEOUT_EN
    wait_rsp("t5_rsp_wait");
    check("t5_err", bus.rsp_err, 1);
    check("t5_product", bus.rsp_product, 0);
    check("t5_clr", clr_at_rsp - mc0, 1);
    check("t5_latency", rsp_cyc - grant_cyc, 3 + 32);
    wait_pops(p0 + 1, "t5_pop_wait");
    hang_mode = 1'b0;
    busy = 2;
    p0 = pop_cnt;
    tick();
    set_req(4'b0001);
    @(negedge clk);
    tick();
    set_req(4'b0000);
    wait_rsp("t5_rsp2_wait");
    check("t5_err_cleared", bus.rsp_err, 0);
    wait_pops(p0 + 1, "t5_pop2_wait");
`else
    repeat (100) @(negedge clk);
    #1;
    check("t5_still_wait", dbg_state, WAIT);
    check("t5_no_rsp", bus.rsp_valid, 0);
    check("t5_no_clr", mc_cnt - mc0, 0);
    check("t5_err_tied", bus.rsp_err, 0);
    tick();
    reset = 1'b1;
    exp_q.delete();
    hang_mode = 1'b0;
    tick();
    reset = 1'b0;
`endif

    tick();
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
